// File: rtl/edge_bit_sampler.sv
// Oversampled receive-bit sampler: counts edges within a bit period, counts bit periods,
// and majority-votes three samples taken around the middle of each bit.
module edge_bit_sampler #(
    parameter logic [5:0] DEFAULT_PRESCALE = 6'd8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic [5:0] Prescale,
    input  logic       edge_count_en,
    input  logic       Data_samp_en,
    output logic [5:0] edge_count,
    output logic [3:0] bit_count,
    output logic       sampled_bit,
    output logic       samp_valid
);

    logic [5:0] p_reg;
    logic [5:0] p_legal;
    logic [5:0] p_last;
    logic [5:0] mid;
    logic [2:0] samp;      // {s2, s1, s0}
    logic       bit_end;
    logic       sampling;
    logic       cap0;
    logic       cap1;
    logic       cap2;
    logic       vote;

    always_comb begin
        // NOTE: default assigned first so every path drives p_legal and no latch is inferred.
        p_legal = 6'd8;
        case (Prescale)
            6'd8, 6'd16, 6'd32: p_legal = Prescale;
            default:            p_legal = 6'd8;
        endcase
    end

    assign p_last   = p_reg - 6'd1;
    assign mid      = {1'b0, p_reg[5:1]};
    assign bit_end  = (edge_count == p_last);
    assign sampling = edge_count_en && Data_samp_en;
    assign cap0     = sampling && (edge_count == mid - 6'd1);
    assign cap1     = sampling && (edge_count == mid);
    assign cap2     = sampling && (edge_count == mid + 6'd1);
    // s2 is being captured this cycle, so vote with the live line value in its place.
    assign vote     = (samp[0] & samp[1]) | (samp[0] & RX_IN) | (samp[1] & RX_IN);

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            p_reg       <= DEFAULT_PRESCALE;
            edge_count  <= 6'd0;
            bit_count   <= 4'd0;
            samp        <= 3'b111;
            sampled_bit <= 1'b1;
            samp_valid  <= 1'b0;
        end else begin
            if (!edge_count_en) begin
                p_reg      <= p_legal;
                edge_count <= 6'd0;
                bit_count  <= 4'd0;
            end else if (bit_end) begin
                edge_count <= 6'd0;
                if (bit_count != 4'd15) begin
                    bit_count <= bit_count + 4'd1;
                end
            end else begin
                edge_count <= edge_count + 6'd1;
            end

            if (!edge_count_en && !Data_samp_en) begin
                samp <= 3'b111;
            end else begin
                if (cap0) samp[0] <= RX_IN;
                if (cap1) samp[1] <= RX_IN;
                if (cap2) samp[2] <= RX_IN;
            end

            samp_valid <= cap2;
            if (cap2) begin
                sampled_bit <= vote;
            end
        end
    end

endmodule

// File: doc/edge_bit_sampler.md
EDGE_BIT_SAMPLER -- requirements
Module: edge_bit_sampler

Interface
REQ-001 Parameter: DEFAULT_PRESCALE, 8, prescale value loaded into the internal prescale register at reset.
REQ-002 CLK  input  1  single system clock; all state updates on its rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 RX_IN  input  1  serial receive line, already synchronised to CLK.
REQ-005 Prescale  input  6  oversampling ratio; legal values 8, 16, 32.
REQ-006 edge_count_en  input  1  counter enable, driven by the receive FSM.
REQ-007 Data_samp_en  input  1  sampler enable, driven by the receive FSM.
REQ-008 edge_count  output  6  registered edge counter within the current bit period.
REQ-009 bit_count  output  4  registered count of completed bit periods in the current frame.
REQ-010 sampled_bit  output  1  registered majority-voted value of the current bit.
REQ-011 samp_valid  output  1  one-cycle pulse marking sampled_bit as updated.

Function
REQ-012 Internal prescale register P SHALL load Prescale on every cycle with edge_count_en=0 and SHALL hold while edge_count_en=1 (mid-frame Prescale changes ignored).
REQ-013 Any Prescale value outside {8,16,32} SHALL be loaded into P as 8.
REQ-014 edge_count_en=0: edge_count<=0 and bit_count<=0 on the next edge.
REQ-015 edge_count_en=1 and edge_count!=P-1: edge_count<=edge_count+1, bit_count holds.
REQ-016 edge_count_en=1 and edge_count==P-1: edge_count<=0, bit_count<=bit_count+1.
REQ-017 bit_count SHALL saturate at 15; the wrap at 15 SHALL still reset edge_count to 0.
REQ-018 First cycle with edge_count_en=1 SHALL present edge_count=0, bit_count=0 (start bit = bit 0).
REQ-019 Sample points: M=P/2; RX_IN SHALL be captured into s0, s1, s2 in the cycles where edge_count equals M-1, M, M+1 respectively, with Data_samp_en=1 and edge_count_en=1.
REQ-020 In the cycle after the s2 capture, sampled_bit SHALL equal majority(s0,s1,s2) and samp_valid SHALL be 1 for exactly that cycle (P=8: captures at 3,4,5; samp_valid while edge_count=6).
REQ-021 A capture point skipped because Data_samp_en=0 SHALL leave that sample register unchanged; samp_valid SHALL pulse only if the s2 capture occurred.
REQ-022 sampled_bit SHALL hold its value between samp_valid pulses, including while disabled.
REQ-023 Data_samp_en=0 and edge_count_en=0 together SHALL clear s0..s2 to 1 (idle line level).
REQ-024 Deassertion of edge_count_en mid-bit SHALL abort the bit: counters clear next edge, no samp_valid for that bit.
REQ-025 Re-assertion of edge_count_en after exactly one disabled cycle SHALL restart from edge_count=0, bit_count=0.
REQ-026 No combinational path from any input to any output.

Reset
REQ-027 With RST=1 at a rising edge: edge_count=0, bit_count=0, sampled_bit=1, samp_valid=0, s0..s2=1, P=DEFAULT_PRESCALE.
REQ-028 RST SHALL take priority over all enables, including mid-frame; the first post-reset cycle SHALL follow REQ-012..REQ-025 from the reset state.

Verification
REQ-029 Prescale=8, both enables high 88 cycles, RX_IN=0 -> edge_count 0..7 repeating, bit_count reaches 11 at cycle 88, samp_valid at cycles 6,14,22,... with sampled_bit=0.
REQ-030 Prescale=16, RX_IN=1 except a 0 glitch at edge_count=8 only -> majority=1, sampled_bit=1, samp_valid while edge_count=10.
REQ-031 Prescale=32 latched, Prescale changed to 8 at edge_count=5 of bit 2 -> counter continues wrapping at 31 until edge_count_en drops; next frame wraps at 7.
REQ-032 Prescale=20 -> P=8; counter wraps at 7.
REQ-033 Enables run 200 cycles at P=8 -> bit_count saturates at 15, edge_count keeps wrapping 0..7.
REQ-034 RST asserted at edge_count=4, bit_count=3 with enables held high -> next cycle all outputs at reset values, then counting restarts from 0/0 with no stale samp_valid.
